// File: rtl/nec_ir_pkg.sv
// rtl/nec_ir_pkg.sv - shared NEC IR timing defaults, state encoding and carrier constants
package nec_ir_pkg;

    // Cycle counts at a 2 MHz clock
    localparam int DEF_LEAD_MARK  = 18000;
    localparam int DEF_LEAD_SPACE = 9000;
    localparam int DEF_REP_SPACE  = 4500;
    localparam int DEF_BIT_MARK   = 1125;
    localparam int DEF_ZERO_SPACE = 1125;
    localparam int DEF_ONE_SPACE  = 3375;
    localparam int DEF_CAR_PERIOD = 52;
    localparam int DEF_CAR_HIGH   = 17;

    localparam int PHASE_W    = 15;
    localparam int BIT_W      = 6;
    localparam int FRAME_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L_MARK  = 3'd1,
        ST_L_SPACE = 3'd2,
        ST_B_MARK  = 3'd3,
        ST_B_SPACE = 3'd4,
        ST_S_MARK  = 3'd5,
        ST_R_SPACE = 3'd6
    } nec_state_t;

endpackage

// File: rtl/nec_ir_carrier.sv
// rtl/nec_ir_carrier.sv - free-running IR carrier, phase-aligned to the start of each mark
module nec_ir_carrier
    import nec_ir_pkg::*;
#(
    parameter int CAR_PERIOD = DEF_CAR_PERIOD,
    parameter int CAR_HIGH   = DEF_CAR_HIGH
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic carrier
);

    localparam int CW = $clog2(CAR_PERIOD + 1);

    logic [CW-1:0] r_cnt;

    // Held at zero outside marks so every mark opens on a high carrier phase
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(CAR_PERIOD - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign carrier = (r_cnt < CW'(CAR_HIGH));

endmodule

// File: rtl/nec_ir_tx.sv
// rtl/nec_ir_tx.sv - NEC IR frame transmitter: leader, 32 data bits MSB first, stop mark, repeat frames
module nec_ir_tx
    import nec_ir_pkg::*;
#(
    parameter int LEAD_MARK  = DEF_LEAD_MARK,
    parameter int LEAD_SPACE = DEF_LEAD_SPACE,
    parameter int REP_SPACE  = DEF_REP_SPACE,
    parameter int BIT_MARK   = DEF_BIT_MARK,
    parameter int ZERO_SPACE = DEF_ZERO_SPACE,
    parameter int ONE_SPACE  = DEF_ONE_SPACE,
    parameter int CAR_PERIOD = DEF_CAR_PERIOD,
    parameter int CAR_HIGH   = DEF_CAR_HIGH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rep_req,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_out,
    output logic        ir_n,
    output logic [2:0]  state_o
);

    localparam logic               DONE_ON_ENTRY = (BIT_MARK == 1);
    localparam logic [PHASE_W-1:0] DONE_PHASE    = PHASE_W'(BIT_MARK - 2);

    nec_state_t         r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [31:0]        r_shift;
    logic               r_rep;
    logic               r_busy;
    logic               r_done;
    logic               r_env;
    logic [PHASE_W-1:0] w_dur;
    logic               w_last;
    logic               w_carrier;

    always_comb begin
        w_dur = '0;
        case (r_state)
            ST_L_MARK:  w_dur = PHASE_W'(LEAD_MARK);
            ST_L_SPACE: w_dur = PHASE_W'(LEAD_SPACE);
            ST_R_SPACE: w_dur = PHASE_W'(REP_SPACE);
            ST_B_MARK:  w_dur = PHASE_W'(BIT_MARK);
            ST_S_MARK:  w_dur = PHASE_W'(BIT_MARK);
            ST_B_SPACE: w_dur = r_shift[31] ? PHASE_W'(ONE_SPACE) : PHASE_W'(ZERO_SPACE);
            default:    w_dur = '0;
        endcase
    end

    assign w_last = (r_phase == w_dur - 1'b1);

    // Envelope, busy and done are set on the same edge as the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rep     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_env     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_phase <= w_last ? '0 : r_phase + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_phase <= '0;
                    if (start) begin
                        r_shift   <= data;
                        r_rep     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_env     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_L_MARK;
                    end else if (rep_req) begin
                        r_rep   <= 1'b1;
                        r_env   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_L_MARK;
                    end
                end
                ST_L_MARK: if (w_last) begin
                    r_env   <= 1'b0;
                    r_state <= r_rep ? ST_R_SPACE : ST_L_SPACE;
                end
                ST_L_SPACE: if (w_last) begin
                    r_env   <= 1'b1;
                    r_state <= ST_B_MARK;
                end
                ST_B_MARK: if (w_last) begin
                    r_env   <= 1'b0;
                    r_state <= ST_B_SPACE;
                end
                ST_B_SPACE: if (w_last) begin
                    r_shift <= {r_shift[30:0], 1'b0};
                    r_env   <= 1'b1;
                    if (r_bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        r_bit_cnt <= '0;
                        r_done    <= DONE_ON_ENTRY;
                        r_state   <= ST_S_MARK;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_state   <= ST_B_MARK;
                    end
                end
                ST_R_SPACE: if (w_last) begin
                    r_env   <= 1'b1;
                    r_done  <= DONE_ON_ENTRY;
                    r_state <= ST_S_MARK;
                end
                ST_S_MARK: begin
                    if (w_last) begin
                        r_env   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_rep   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_phase == DONE_PHASE) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_env   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    nec_ir_carrier #(
        .CAR_PERIOD (CAR_PERIOD),
        .CAR_HIGH   (CAR_HIGH)
    ) u_carrier (
        .clk     (clk),
        .reset   (reset),
        .en      (r_env),
        .carrier (w_carrier)
    );

    assign ir_env  = r_env;
    assign ir_out  = r_env & w_carrier;
    assign ir_n    = ~r_env;
    assign busy    = r_busy;
    assign done    = r_done;
    assign state_o = r_state;

endmodule

// File: tb/tb_nec_ir_tx.sv
// tb/tb_nec_ir_tx.sv - self-checking bench for nec_ir_tx with a segment-level waveform model and loopback decoder
module tb_nec_ir_tx;

    localparam int LM = 160;
    localparam int LS = 80;
    localparam int RS = 40;
    localparam int BM = 6;
    localparam int ZS = 6;
    localparam int OS = 18;
    localparam int CP = 52;
    localparam int CH = 17;

    localparam int S_IDLE = 0, S_LM = 1, S_LS = 2, S_BM = 3, S_BS = 4, S_SM = 5, S_RS = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rep_req = 1'b0;
    logic [31:0] data = '0;
    logic        busy, done, ir_env, ir_out, ir_n;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    nec_ir_tx #(
        .LEAD_MARK(LM), .LEAD_SPACE(LS), .REP_SPACE(RS), .BIT_MARK(BM),
        .ZERO_SPACE(ZS), .ONE_SPACE(OS), .CAR_PERIOD(CP), .CAR_HIGH(CH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rep_req(rep_req), .data(data),
        .busy(busy), .done(done), .ir_env(ir_env), .ir_out(ir_out), .ir_n(ir_n),
        .state_o(state_o)
    );

    typedef struct {
        logic       env;
        logic       done;
        logic [2:0] st;
        int         off;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    logic        dec_prev = 1'b1;
    int          dec_run = 0;
    bit          dec_collect = 1'b0;
    int          dec_bits = 0;
    logic [31:0] dec_acc = '0;
    logic [31:0] dec_word = '0;
    int          dec_cnt = 0;
    int          rep_cnt = 0;

    function automatic void push_seg(int st, logic env, int len, logic last);
        for (int k = 0; k < len; k++) begin
            exp_t e;
            e.env  = env;
            e.done = last && (k == len - 1);
            e.st   = 3'(st);
            e.off  = k;
            exp_q.push_back(e);
        end
    endfunction

    // Expected waveform built from the frame's mark/space segments
    function automatic void push_frame(logic [31:0] d, logic rep);
        push_seg(S_LM, 1'b1, LM, 1'b0);
        if (rep) begin
            push_seg(S_RS, 1'b0, RS, 1'b0);
        end else begin
            push_seg(S_LS, 1'b0, LS, 1'b0);
            for (int i = 31; i >= 0; i--) begin
                push_seg(S_BM, 1'b1, BM, 1'b0);
                push_seg(S_BS, 1'b0, d[i] ? OS : ZS, 1'b0);
            end
        end
        push_seg(S_SM, 1'b1, BM, 1'b1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic compare();
        exp_t e;
        logic [7:0] act, expv;
        act = {ir_env, busy, done, ir_out, ir_n, state_o};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            expv = {e.env, 1'b1, e.done, e.env && ((e.off % CP) < CH), ~e.env, e.st};
        end else begin
            expv = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'(S_IDLE)};
        end
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL cycle t=%0t {env,busy,done,out,n,state} got %b expected %b", $time, act, expv);
        end
    endtask

    // Receiver-side view of ir_n: classify space lengths into leader, repeat and bit values
    task automatic decode();
        if (ir_n === dec_prev) begin
            dec_run++;
        end else begin
            if (dec_prev == 1'b1) begin
                if (dec_run == LS) begin
                    dec_collect = 1'b1;
                    dec_bits    = 0;
                    dec_acc     = '0;
                end else if (dec_run == RS && !dec_collect) begin
                    rep_cnt++;
                end else if (dec_collect && (dec_run == OS || dec_run == ZS)) begin
                    dec_acc = {dec_acc[30:0], (dec_run == OS)};
                    dec_bits++;
                    if (dec_bits == 32) begin
                        dec_word    = dec_acc;
                        dec_cnt++;
                        dec_collect = 1'b0;
                    end
                end
            end
            dec_prev = ir_n;
            dec_run  = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            compare();
            decode();
        end
    endtask

    task automatic send(input logic s, input logic r, input logic [31:0] d, output int qlen);
        start   = s;
        rep_req = r;
        data    = d;
        push_frame(d, !s);
        qlen = exp_q.size();
    endtask

    task automatic run_frame(input int inject_at, output int cyc, output int dn, output int hi_lead);
        cyc = 0; dn = 0; hi_lead = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (i == 0) begin start = 1'b0; rep_req = 1'b0; end
            if (i == inject_at) begin start = 1'b1; rep_req = 1'b1; data = 32'hFFFF_FFFF; end
            if (i == inject_at + 1) begin start = 1'b0; rep_req = 1'b0; data = 32'h0; end
            if (busy === 1'b1) begin
                cyc++;
                if (done === 1'b1) dn++;
                if (cyc <= LM && ir_out === 1'b1) hi_lead++;
            end else begin
                break;
            end
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_timeout: busy still %b after 2000 cycles", busy);
        end
    endtask

    int qlen, cyc, dn, hi;

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("reset_state", 32'(state_o), 32'(S_IDLE));
        chk("reset_ir_n", 32'(ir_n), 32'h1);
        reset = 1'b0;
        tick();

        // Full frame with an ignored start/rep_req pulse and data change in the middle
        send(1'b1, 1'b0, 32'h00FF_A55A, qlen);
        chk("model_len_a", 32'(qlen), 32'd822);
        run_frame(300, cyc, dn, hi);
        chk("busy_len_a", 32'(cyc), 32'd822);
        chk("done_cnt_a", 32'(dn), 32'd1);
        chk("lead_carrier_hi", 32'(hi), 32'd55);
        chk("dec_word_a", dec_word, 32'h00FF_A55A);
        chk("dec_cnt_a", 32'(dec_cnt), 32'd1);
        chk("queue_drained_a", 32'(exp_q.size()), 32'd0);

        send(1'b0, 1'b1, 32'h0, qlen);
        chk("model_len_rep", 32'(qlen), 32'd206);
        run_frame(-5, cyc, dn, hi);
        chk("busy_len_rep", 32'(cyc), 32'd206);
        chk("done_cnt_rep", 32'(dn), 32'd1);
        chk("rep_cnt_1", 32'(rep_cnt), 32'd1);
        chk("dec_cnt_rep", 32'(dec_cnt), 32'd1);

        send(1'b1, 1'b0, 32'h1234_5678, qlen);
        run_frame(-5, cyc, dn, hi);
        chk("busy_len_loop", 32'(cyc), 32'd786);
        chk("dec_word_loop", dec_word, 32'h1234_5678);
        send(1'b0, 1'b1, 32'h0, qlen);
        run_frame(-5, cyc, dn, hi);
        chk("rep_cnt_2", 32'(rep_cnt), 32'd2);

        send(1'b1, 1'b1, 32'hA5A5_0F0F, qlen);
        run_frame(-5, cyc, dn, hi);
        chk("busy_len_both", 32'(cyc), 32'd822);
        chk("dec_word_both", dec_word, 32'hA5A5_0F0F);
        chk("rep_cnt_both", 32'(rep_cnt), 32'd2);

        // Reset mid-frame with a simultaneous start that must be dropped
        send(1'b1, 1'b0, 32'hC3C3_3C3C, qlen);
        for (int i = 0; i < 250; i++) begin
            tick();
            if (i == 0) start = 1'b0;
        end
        reset = 1'b1;
        start = 1'b1;
        data  = 32'hDEAD_BEEF;
        exp_q.delete();
        dec_collect = 1'b0;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ir_n", 32'(ir_n), 32'h1);
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        for (int i = 0; i < 9; i++) tick();
        send(1'b1, 1'b0, 32'h0F0F_F0F0, qlen);
        run_frame(-5, cyc, dn, hi);
        chk("busy_len_post_rst", 32'(cyc), 32'd822);
        chk("dec_word_post_rst", dec_word, 32'h0F0F_F0F0);
        chk("dec_cnt_total", 32'(dec_cnt), 32'd4);
        for (int i = 0; i < 5; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nec_ir_tx.md
NEC_IR_TX -- requirements
Module: nec_ir_tx

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- LEAD_MARK, 18000, leader mark cycles (9 ms at 2 MHz)
- LEAD_SPACE, 9000, leader space cycles (4.5 ms)
- REP_SPACE, 4500, repeat-frame space cycles (2.25 ms)
- BIT_MARK, 1125, bit and stop mark cycles (562.5 us)
- ZERO_SPACE, 1125, logic-0 space cycles
- ONE_SPACE, 3375, logic-1 space cycles (1.6875 ms)
- CAR_PERIOD, 52, carrier period cycles (~38 kHz)
- CAR_HIGH, 17, carrier high cycles per period (~1/3 duty)

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock, 2 MHz nominal
- reset, in, 1, synchronous active-high reset
- start, in, 1, one-cycle request to send a full frame
- rep_req, in, 1, one-cycle request to send a repeat frame
- data, in, 32, frame payload, sampled on accepted start
- busy, out, 1, high while a frame is in progress
- done, out, 1, one-cycle pulse on the last cycle of a frame
- ir_env, out, 1, envelope, 1 = mark
- ir_out, out, 1, ir_env gated by carrier, drives IR LED
- ir_n, out, 1, ~ir_env, demodulated-receiver polarity for loopback
- state_o, out, 3, current FSM state, debug

REQ-003 Reset is reset: synchronous, active-high. Clock is clk.

Function
REQ-004 FSM states: IDLE, L_MARK, L_SPACE, B_MARK, B_SPACE, S_MARK, R_SPACE. One 15-bit phase counter and one 6-bit bit counter.
REQ-005 IDLE: start=1 -> latch data into the shift register, go to L_MARK. rep_req=1 (start=0) -> L_MARK with a repeat flag set. Start wins if both are high.
REQ-006 start and rep_req are ignored while busy=1. No queuing.
REQ-007 Each timed state holds for exactly its parameter count of cycles, counted from its first cycle, then advances.
REQ-008 Transitions:
- L_MARK -> L_SPACE, or R_SPACE if the repeat flag is set.
- L_SPACE -> B_MARK.
- B_MARK -> B_SPACE.
- B_SPACE -> B_MARK while bits remain, else S_MARK.
- R_SPACE -> S_MARK.
- S_MARK -> IDLE.
REQ-009 Bits are sent MSB first (data[31] first). B_SPACE lasts ONE_SPACE for a 1 and ZERO_SPACE for a 0. Shift left one place at the end of each B_SPACE. Exactly 32 bits per frame.
REQ-010 ir_env = 1 in L_MARK, B_MARK and S_MARK, else 0. ir_n is the inverse of ir_env.
REQ-011 Timing is registered: ir_env rises on the clock edge that enters a mark state.
- The first L_MARK cycle is the cycle after start is sampled (latency 1).
REQ-012 Carrier counter:
- Counts 0..CAR_PERIOD-1 and wraps to 0.
- Held at 0 when ir_env = 0, so every mark begins at carrier phase 0.
- carrier = 1 when count < CAR_HIGH.
- ir_out = ir_env & carrier.
REQ-013 busy = 1 in every non-IDLE state. done pulses on the final S_MARK cycle. busy falls on the following cycle.
REQ-014 Total full-frame length = 18000 + 9000 + 32*1125 + sum(bit spaces) + 1125 cycles. Repeat-frame length = 18000 + 4500 + 1125 = 23625 cycles.
REQ-015 Data changes while busy have no effect on the frame in progress.

Reset
REQ-016 reset=1 on any cycle, including mid-frame, forces all of the following next cycle:
- FSM to IDLE
- all counters and the shift register to 0
- repeat flag cleared
- busy=0, done=0, ir_env=0, ir_out=0, ir_n=1
REQ-017 No partial frame resumes after reset. A start asserted in the same cycle as reset is dropped.

Structure
REQ-018 Timing defaults, state encoding and carrier constants live in a shared package, nec_ir_pkg, used by both the IR decoder and this block.
REQ-019 Carrier generation is one sub-module, nec_ir_carrier (inputs clk, reset, en; output carrier). The rest of the logic is flat.

Verification
REQ-020 Full frame, data=32'h00FF_A55A. Required response:
- ir_env high for 18000 cycles, low for 9000.
- 32 bit marks of 1125 cycles, spaces matching the bits MSB first.
- stop mark of 1125 cycles.
- done once; busy low afterwards.
REQ-021 Repeat request. Required response:
- mark 18000, space 4500, mark 1125, then idle.
- total busy time 23625 cycles; no bit marks.
REQ-022 Loopback. Drive ir_n into the IR decoder with data=32'h1234_5678:
- the decoder reports 32'h1234_5678 after its timeout.
- a following rep_req makes the decoder pulse rep.
REQ-023 Reset at cycle 20000 of a frame: outputs reach their idle values next cycle, and a start at cycle 20010 begins a clean new frame.
REQ-024 Carrier and overlap checks:
- During marks ir_out has period 52 with 17 high cycles per period, and is 0 in spaces.
- start asserted while busy leaves the frame unchanged.
- start and rep_req together send a full frame.
